// File: rtl/icache_refill_bridge_if.sv
// AXI4 read-address / read-data channel bundle between the icache refill
// bridge (master) and the AXI read crossbar (slave).
interface icache_refill_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_refill_bridge.sv
// Turns icache line-refill and uncached word reads into AXI4 read bursts and
// returns the data as a single-cycle response pulse. LINE_WORDS is a power of two.
//
// state   | meaning
// IDLE    | sample requests, line refill wins over uncached read
// AR      | arvalid held with stable address/id/len until arready
// R       | rready high, beats stored at word[beat_cnt]
// RESP    | one-cycle ret_valid or iucache_rvalid_o pulse
module icache_refill_bridge #(
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [3:0]  LINE_ID    = 4'd0,
    parameter logic [3:0]  UNCACHE_ID = 4'd1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_req,
    input  logic [31:0]              rd_addr,
    output logic                     ret_valid,
    output logic [32*LINE_WORDS-1:0] ret_data,
    input  logic                     iucache_ren_i,
    input  logic [31:0]              iucache_addr_i,
    output logic                     iucache_rvalid_o,
    output logic [31:0]              iucache_rdata_o,
    icache_refill_bridge_if.master   axi
);
    localparam int unsigned LINE_BITS = 32 * LINE_WORDS;
    localparam int unsigned CNT_W     = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W     = CNT_W + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RESP} state_e;

    state_e                 state_q, state_d;
    logic                   kind_line_q, kind_line_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [LINE_BITS-1:0]   ret_data_q, ret_data_d;
    logic [31:0]            iuc_rdata_q, iuc_rdata_d;
    logic                   ret_valid_q, ret_valid_d;
    logic                   iuc_rvalid_q, iuc_rvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic [31:0]            araddr_q, araddr_d;
    logic [3:0]             arid_q, arid_d;
    logic [7:0]             arlen_q, arlen_d;
    logic                   beat;

    assign beat = rready_q && axi.rvalid;

    always_comb begin
        state_d     = state_q;
        kind_line_d = kind_line_q;
        beat_cnt_d  = beat_cnt_q;
        line_d      = line_q;
        ret_data_d  = ret_data_q;
        iuc_rdata_d = iuc_rdata_q;
        araddr_d    = araddr_q;
        arid_d      = arid_q;
        arlen_d     = arlen_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    araddr_d    = {rd_addr[31:OFF_W], OFF_W'(0)};
                    arid_d      = LINE_ID;
                    arlen_d     = 8'(LINE_WORDS - 1);
                    kind_line_d = 1'b1;
                    line_d      = '0;
                    beat_cnt_d  = '0;
                    state_d     = ST_AR;
                end else if (iucache_ren_i) begin
                    araddr_d    = {iucache_addr_i[31:2], 2'b00};
                    arid_d      = UNCACHE_ID;
                    arlen_d     = 8'd0;
                    kind_line_d = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = ST_AR;
                end
            end
            ST_AR: begin
                if (arvalid_q && axi.arready) state_d = ST_R;
            end
            ST_R: begin
                if (beat) begin
                    // Beats past the line length wrap and overwrite word 0 onward.
                    if (kind_line_q) line_d[32*int'(beat_cnt_q) +: 32] = axi.rdata;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (axi.rlast) begin
                        state_d = ST_RESP;
                        if (kind_line_q) ret_data_d  = line_d;
                        else             iuc_rdata_d = axi.rdata;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        arvalid_d    = (state_d == ST_AR);
        rready_d     = (state_d == ST_R);
        ret_valid_d  = (state_q == ST_R) && (state_d == ST_RESP) && kind_line_q;
        iuc_rvalid_d = (state_q == ST_R) && (state_d == ST_RESP) && !kind_line_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            kind_line_q  <= 1'b0;
            beat_cnt_q   <= '0;
            line_q       <= '0;
            ret_data_q   <= '0;
            iuc_rdata_q  <= '0;
            ret_valid_q  <= 1'b0;
            iuc_rvalid_q <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            araddr_q     <= '0;
            arid_q       <= '0;
            arlen_q      <= '0;
        end else begin
            state_q      <= state_d;
            kind_line_q  <= kind_line_d;
            beat_cnt_q   <= beat_cnt_d;
            line_q       <= line_d;
            ret_data_q   <= ret_data_d;
            iuc_rdata_q  <= iuc_rdata_d;
            ret_valid_q  <= ret_valid_d;
            iuc_rvalid_q <= iuc_rvalid_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            araddr_q     <= araddr_d;
            arid_q       <= arid_d;
            arlen_q      <= arlen_d;
        end
    end

    assign ret_valid        = ret_valid_q;
    assign ret_data         = ret_data_q;
    assign iucache_rvalid_o = iuc_rvalid_q;
    assign iucache_rdata_o  = iuc_rdata_q;
    assign axi.arvalid      = arvalid_q;
    assign axi.araddr       = araddr_q;
    assign axi.arid         = arid_q;
    assign axi.arlen        = arlen_q;
    assign axi.arsize       = 3'b010;
    assign axi.arburst      = 2'b01;
    assign axi.rready       = rready_q;

    // Error responses are passed through as data; address offset bits are dropped.
    logic unused_ok;
    assign unused_ok = ^{axi.rresp, rd_addr[OFF_W-1:0], iucache_addr_i[1:0]};
endmodule

// File: tb/tb_icache_refill_bridge.sv
// Bench for icache_refill_bridge: vector table, hand-written corner sequences
// and random transactions checked against a beat-level model of the line buffer.
module tb_icache_refill_bridge;
    localparam int LW = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         iucache_ren_i;
    logic [31:0]  iucache_addr_i;
    logic         iucache_rvalid_o;
    logic [31:0]  iucache_rdata_o;

    icache_refill_bridge_if axi();

    icache_refill_bridge #(.LINE_WORDS(LW), .LINE_ID(4'd0), .UNCACHE_ID(4'd1)) dut (
        .clk              (clk),
        .reset            (reset),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .ret_valid        (ret_valid),
        .ret_data         (ret_data),
        .iucache_ren_i    (iucache_ren_i),
        .iucache_addr_i   (iucache_addr_i),
        .iucache_rvalid_o (iucache_rvalid_o),
        .iucache_rdata_o  (iucache_rdata_o),
        .axi              (axi)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        bit          is_line;
        logic [31:0] addr;
        int          ar_stall;
        int          gap;
        int          nbeats;
        logic [31:0] x_araddr;
        logic [3:0]  x_arid;
        logic [7:0]  x_arlen;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " ctrl"}, 256'({ret_valid, iucache_rvalid_o, iucache_rdata_o, axi.arvalid,
                                     axi.araddr, axi.arid, axi.arlen, axi.rready}), 256'(0));
        check({name, " ret_data"}, ret_data, 256'(0));
    endtask

    // One complete transaction; the slave model stalls arready for ar_stall
    // cycles, inserts gap idle cycles between beats and asserts rlast on beat nbeats-1.
    task automatic do_txn(input bit is_line, input logic [31:0] addr, input int ar_stall,
                          input int gap, input int nbeats, input bit rnd,
                          input logic [31:0] x_araddr, input logic [3:0] x_arid,
                          input logic [7:0] x_arlen, input string tag);
        logic [31:0]  d;
        logic [255:0] x_line;
        logic [31:0]  x_word;
        int           bad;
        x_line = '0;
        x_word = '0;
        bad    = 0;
        if (is_line) begin rd_req = 1'b1; rd_addr = addr; end
        else begin iucache_ren_i = 1'b1; iucache_addr_i = addr; end
        cyc = 0;
        tick();
        check({tag, " ar"}, 256'({axi.arvalid, axi.araddr, axi.arid, axi.arlen, axi.rready}),
              256'({1'b1, x_araddr, x_arid, x_arlen, 1'b0}));
        for (int s = 0; s < ar_stall; s++) begin
            tick();
            if (!axi.arvalid || axi.araddr !== x_araddr || axi.arid !== x_arid ||
                axi.arlen !== x_arlen || axi.rready) bad++;
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0) begin
                for (int g = 0; g < gap; g++) begin
                    axi.rvalid = 1'b0;
                    axi.rlast  = 1'b0;
                    tick();
                    if (!axi.rready || axi.arvalid || ret_valid || iucache_rvalid_o) bad++;
                end
            end
            if (!axi.rready || axi.arvalid || ret_valid || iucache_rvalid_o) bad++;
            d = rnd ? $urandom : (is_line ? x_araddr + 32'(4 * b) : (32'hFF00_0000 | x_araddr));
            axi.rvalid = 1'b1;
            axi.rdata  = d;
            axi.rresp  = 2'($urandom_range(0, 3));
            axi.rlast  = (b == nbeats - 1);
            x_line[(b % LW) * 32 +: 32] = d;
            x_word = d;
            tick();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        check({tag, " pulse"}, 256'({ret_valid, iucache_rvalid_o}), 256'(is_line ? 2'b10 : 2'b01));
        if (is_line) check({tag, " line"}, ret_data, x_line);
        else         check({tag, " word"}, 256'(iucache_rdata_o), 256'(x_word));
        check({tag, " handshake"}, 256'(bad), 256'(0));
        if (is_line) rd_req = 1'b0;
        else         iucache_ren_i = 1'b0;
        tick();
        check({tag, " after"}, 256'({ret_valid, iucache_rvalid_o, axi.arvalid, axi.rready}), 256'(0));
        if (is_line) check({tag, " hold"}, ret_data, x_line);
        else         check({tag, " hold"}, 256'(iucache_rdata_o), 256'(x_word));
    endtask

    initial begin
        logic [31:0] a;
        bit          ln;
        int          nb;

        vecs[0] = '{1'b1, 32'h0080_0014, 0, 0, 8,  32'h0080_0000, 4'd0, 8'd7, "line_basic"};
        vecs[1] = '{1'b0, 32'h0000_0008, 0, 0, 1,  32'h0000_0008, 4'd1, 8'd0, "unc_basic"};
        vecs[2] = '{1'b1, 32'h0000_1234, 3, 2, 8,  32'h0000_1220, 4'd0, 8'd7, "line_bp"};
        vecs[3] = '{1'b1, 32'h0000_0040, 0, 0, 4,  32'h0000_0040, 4'd0, 8'd7, "line_early"};
        vecs[4] = '{1'b0, 32'hDEAD_BEEF, 1, 0, 1,  32'hDEAD_BEEC, 4'd1, 8'd0, "unc_stall"};
        vecs[5] = '{1'b1, 32'h0000_303C, 0, 1, 10, 32'h0000_3020, 4'd0, 8'd7, "line_wrap"};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 0, 0, 1,  32'hFFFF_FFFC, 4'd1, 8'd0, "unc_top"};

        reset = 1'b1;
        rd_req = 1'b0; rd_addr = '0;
        iucache_ren_i = 1'b0; iucache_addr_i = '0;
        axi.arready = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        check("consts", 256'({axi.arsize, axi.arburst}), 256'({3'b010, 2'b01}));
        reset = 1'b0;
        tick();

        foreach (vecs[i])
            do_txn(vecs[i].is_line, vecs[i].addr, vecs[i].ar_stall, vecs[i].gap, vecs[i].nbeats,
                   1'b0, vecs[i].x_araddr, vecs[i].x_arid, vecs[i].x_arlen, vecs[i].name);

        // Both requests held: line first, the uncached read after one IDLE cycle.
        iucache_ren_i  = 1'b1;
        iucache_addr_i = 32'h0000_0100;
        do_txn(1'b1, 32'h0000_0040, 0, 0, 8, 1'b0, 32'h0000_0040, 4'd0, 8'd7, "both_line");
        do_txn(1'b0, 32'h0000_0100, 0, 0, 1, 1'b0, 32'h0000_0100, 4'd1, 8'd0, "both_unc");

        // Reset after three beats of a line burst, then a clean refill.
        rd_req  = 1'b1;
        rd_addr = 32'h0000_0200;
        tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = 32'hBAD0_0000 + 32'(b);
            tick();
        end
        axi.rvalid = 1'b0;
        rd_req = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        check_reset_outputs("mid_reset");
        tick();
        check("mid_reset idle", 256'({axi.arvalid, axi.rready}), 256'(0));
        do_txn(1'b1, 32'h0000_0208, 0, 0, 8, 1'b0, 32'h0000_0200, 4'd0, 8'd7, "post_reset");

        for (int t = 0; t < 40; t++) begin
            a  = $urandom;
            ln = 1'($urandom_range(0, 1));
            nb = ln ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 2));
            do_txn(ln, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), nb, 1'b1,
                   ln ? (a & ~32'h1F) : (a & ~32'h3), ln ? 4'd0 : 4'd1, ln ? 8'd7 : 8'd0,
                   $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/icache_refill_bridge.md
# icache_refill_bridge

Memory-side responder for the instruction cache's read interfaces. It accepts a cached line-refill request (`rd_req`/`rd_addr`) or an uncached single-word request (`iucache_ren_i`/`iucache_addr_i`). Each request becomes an AXI4 read burst, and the data returns as a one-cycle `ret_valid` pulse with a full 256-bit line, or an `iucache_rvalid_o` pulse with one word. It sits between `icache` and the AXI read crossbar, replacing the behavioural memory model used in the icache bench.

## Interface
Parameters:
- LINE_WORDS, 8, 32-bit words per cache line; sets `arlen` = LINE_WORDS-1 and ret_data width = 32*LINE_WORDS
- LINE_ID, 4'd0, AXI `arid` used for line refills
- UNCACHE_ID, 4'd1, AXI `arid` used for uncached reads

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rd_req  in  1  line refill request; held by icache until ret_valid
- rd_addr  in  32  refill address (any byte within line)
- ret_valid  out  1  one-cycle pulse, ret_data valid
- ret_data  out  256  line; word i at bits [32i+31:32i] = address base+4i
- iucache_ren_i  in  1  uncached read request; held until iucache_rvalid_o
- iucache_addr_i  in  32  uncached word address
- iucache_rvalid_o  out  1  one-cycle pulse, iucache_rdata_o valid
- iucache_rdata_o  out  32  uncached read data
- arid  out  4  AXI read id
- araddr  out  32  AXI read address
- arlen  out  8  burst length minus one
- arsize  out  3  fixed 3'b010 (4 bytes)
- arburst  out  2  fixed 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address ready
- rdata  in  32  read data beat
- rresp  in  2  read response (ignored; data passed through)
- rlast  in  1  last beat
- rvalid  in  1  beat valid
- rready  out  1  beat ready

## Operation
- States: IDLE, AR, R, RESP.
- IDLE:
  - rd_req=1: latch base = {rd_addr[31:5],5'b0}, arid=LINE_ID, arlen=LINE_WORDS-1, kind=LINE, clear line buffer to 0, go to AR.
  - Otherwise iucache_ren_i=1: latch araddr = {iucache_addr_i[31:2],2'b00}, arid=UNCACHE_ID, arlen=0, kind=UNC, go to AR.
  - rd_req has priority when both are high. The losing request stays held and is served after RESP.
- AR: arvalid=1 with stable araddr/arid/arlen. On arvalid&&arready, go to R.
- R: rready=1.
  - Each rvalid beat writes rdata to word[beat_cnt]; the 3-bit beat_cnt then increments.
  - LINE: beat_cnt wraps after 7, so extra beats overwrite word 0 onward.
  - UNC: the beat goes to the word register.
  - rvalid&&rlast: go to RESP. An early rlast leaves unreceived words at 0.
- RESP: one cycle.
  - LINE: ret_valid=1.
  - UNC: iucache_rvalid_o=1.
  - Data outputs hold this value until the next response.
  - Requests are not sampled in RESP. Next state is IDLE, so the requester must drop its request in the cycle after the pulse.
- No flush or abort input: a started burst always runs to completion. icache discards stale data.
- rresp is not checked; error beats are returned as data.

## Timing
- Reset values: ret_valid=0, ret_data=0, iucache_rvalid_o=0, iucache_rdata_o=0, arvalid=0, araddr=0, arid=0, arlen=0, rready=0, state=IDLE.
- arsize and arburst are constants.
- Reset mid-burst: return to IDLE next cycle and drop all held state. The bench does not leave the AXI slave with beats outstanding across reset.
- All outputs are registered.
- Request sampled in IDLE at cycle 0 → arvalid=1 from cycle 1.
- Line, best case (arready=1, rvalid continuous): beats in cycles 2–9, ret_valid in cycle 10. Latency is 10 cycles plus AXI stalls.
- Uncached, best case: beat in cycle 2, iucache_rvalid_o in cycle 3.
- arvalid stays high until accepted; araddr/arid/arlen do not change while arvalid=1.
- rready=1 only in R; beats presented outside R are not accepted.
- Back-to-back requests: minimum gap of one IDLE cycle after RESP.

## Test plan
- Line refill: rd_addr=0x0080_0014, arready=1, slave returns base+4i → araddr=0x0080_0000, arlen=7, arid=0; ret_valid in cycle 10 with ret_data word i = 0x0080_0000+4i; single-cycle pulse.
- Uncached read: iucache_addr_i=0x0000_0008, slave returns 0xFF00_0008 → arlen=0, arid=1, araddr=0x8; iucache_rvalid_o in cycle 3 with data 0xFF00_0008.
- Simultaneous rd_req (0x40) and iucache_ren_i (0x100), both held → line burst first, ret_valid; then one IDLE cycle; then uncached AR at 0x100 and iucache_rvalid_o.
- Backpressure: arready low for 3 cycles, rvalid gaps of 2 cycles between beats → arvalid and araddr stable throughout, all 8 words correct, ret_valid exactly once after rlast.
- Early rlast on beat 4 (words 0–3 received) → ret_valid, words 4–7 = 0.
- Reset asserted in R after 3 beats → next cycle state IDLE, all outputs 0; a new rd_req completes normally with correct data.
